// File: rtl/decode_pkg.sv
// decode_pkg: instruction field layout, opcodes and register-file sizing shared
// by decode_issue and the register file.
`default_nettype none

package decode_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int OPW  = 6;

  localparam logic [OPW-1:0] OP_NOP   = 6'h00;
  localparam logic [OPW-1:0] OP_STORE = 6'h2B;
  localparam logic [OPW-1:0] OP_HALT  = 6'h3F;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic op_writes_rd(input logic [OPW-1:0] op);
    return (op != OP_NOP) && (op != OP_STORE) && (op != OP_HALT);
  endfunction

  function automatic logic [31:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// ============================================================================
// decode_scoreboard: busy bit per register; set wins over a same-edge clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_scoreboard
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_add,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_add,
  input  logic            flush,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  // Clear applied first so a same-register set overrides it.
  always_comb begin
    w_busy_next = r_busy;
    if (clr_en) w_busy_next[clr_add] = 1'b0;
    if (set_en) w_busy_next[set_add] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// ============================================================================
// decode_issue: splits fetched instructions, stalls on register hazards and
// issues registered fields to execute in step with the register file read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_issue
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            flush,
  input  logic            wb_enable,
  input  logic [AW-1:0]   wb_add,
  output logic [AW-1:0]   r1_add,
  output logic [AW-1:0]   r2_add,
  output logic            ex_valid,
  output logic [OPW-1:0]  ex_op,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_we,
  output logic [31:0]     ex_imm,
  output logic            halted
);

  logic [OPW-1:0]  w_op;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic            w_writes_rd;
  logic            w_hazard;
  logic            w_issue;
  logic [NREG-1:0] w_busy;

  logic            r_ex_valid;
  logic [OPW-1:0]  r_ex_op;
  logic [AW-1:0]   r_ex_rd;
  logic            r_ex_we;
  logic [31:0]     r_ex_imm;
  logic            r_halted;

  assign w_op  = instr[OP_MSB:OP_LSB];
  assign w_rd  = instr[RD_MSB:RD_LSB];
  assign w_rs1 = instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = instr[RS2_MSB:RS2_LSB];

  assign w_writes_rd = op_writes_rd(w_op);
  // Both sources checked regardless of opcode; rd check keeps writes in order.
  assign w_hazard    = w_busy[w_rs1] | w_busy[w_rs2] | (w_writes_rd & w_busy[w_rd]);
  assign instr_ready = !w_hazard && !r_halted && !flush;
  assign w_issue     = instr_valid && instr_ready;

  assign r1_add = w_rs1;
  assign r2_add = w_rs2;

  decode_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (w_issue && w_writes_rd),
    .set_add (w_rd),
    .clr_en  (wb_enable),
    .clr_add (wb_add),
    .flush   (flush),
    .busy    (w_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_we    <= 1'b0;
      r_ex_imm   <= '0;
      r_halted   <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_op    <= w_op;
      r_ex_rd    <= w_rd;
      r_ex_we    <= w_writes_rd;
      r_ex_imm   <= sext_imm(instr[IMM_MSB:IMM_LSB]);
      if (w_op == OP_HALT) r_halted <= 1'b1;
    end else begin
      // Also the flush path: instr_ready is low, so nothing issues.
      r_ex_valid <= 1'b0;
      r_ex_we    <= 1'b0;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_rd    = r_ex_rd;
  assign ex_we    = r_ex_we;
  assign ex_imm   = r_ex_imm;
  assign halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vector table, hand sequences for reset/halt and the
// scoreboard collision, then random traffic against a reference model.
`default_nettype none

module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        flush = 1'b0;
  logic        wb_enable = 1'b0;
  logic [4:0]  wb_add = '0;
  logic [4:0]  r1_add, r2_add;
  logic        ex_valid, ex_we, halted;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_imm;

  logic        sb_set_en = 1'b0, sb_clr_en = 1'b0, sb_flush = 1'b0;
  logic [4:0]  sb_set_add = '0, sb_clr_add = '0;
  logic [31:0] sb_busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .wb_enable(wb_enable), .wb_add(wb_add),
    .r1_add(r1_add), .r2_add(r2_add), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_imm(ex_imm), .halted(halted)
  );

  decode_scoreboard sb (
    .clk(clk), .reset(reset), .set_en(sb_set_en), .set_add(sb_set_add),
    .clr_en(sb_clr_en), .clr_add(sb_clr_add), .flush(sb_flush), .busy(sb_busy)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_add;
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_we;
    logic [5:0]  exp_op;
    logic [4:0]  exp_rd;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[16];

  // Reference model state (spec-level: a set of pending destinations).
  bit [31:0] m_pending;
  bit        m_halted;
  bit        m_valid, m_we;
  bit [5:0]  m_op;
  bit [4:0]  m_rd;
  bit [31:0] m_imm;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; flush = 1'b0; wb_enable = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_pending = '0; m_halted = 0; m_valid = 0; m_we = 0; m_op = '0; m_rd = '0; m_imm = '0;
  endtask

  task automatic model_cycle();
    bit [5:0]  op;
    bit [4:0]  rd, rs1, rs2;
    bit        wr, exp_ready, iss;
    op  = instr[31:26]; rd = instr[25:21]; rs1 = instr[20:16]; rs2 = instr[15:11];
    wr  = !(op == 6'h00 || op == 6'h2B || op == 6'h3F);
    exp_ready = !flush && !m_halted && !m_pending[rs1] && !m_pending[rs2] &&
                !(wr && m_pending[rd]);
    #1;
    chk("rnd_ready", {31'd0, instr_ready}, {31'd0, exp_ready});
    chk("rnd_r1", {27'd0, r1_add}, {27'd0, rs1});
    iss = instr_valid && exp_ready;
    @(posedge clk);
    if (flush) begin
      m_pending = '0;
    end else begin
      if (wb_enable) m_pending = m_pending & ~(32'd1 << wb_add);
      if (iss && wr) m_pending = m_pending | (32'd1 << rd);
    end
    m_valid = iss;
    m_we    = iss && wr;
    if (iss) begin
      m_op = op; m_rd = rd; m_imm = 32'(signed'(instr[15:0]));
      if (op == 6'h3F) m_halted = 1;
    end
    #1;
    chk("rnd_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("rnd_we", {31'd0, ex_we}, {31'd0, m_we});
    chk("rnd_op", {26'd0, ex_op}, {26'd0, m_op});
    chk("rnd_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    chk("rnd_imm", ex_imm, m_imm);
  endtask

  initial begin
    vecs[0]  = '{1, enc(6'h01, 3, 1, 16'h0002),  0, 0, 0, 1, 1, 1, 6'h01, 3, 32'h2};
    vecs[1]  = '{1, enc(6'h01, 4, 3, 16'h0000),  0, 0, 0, 0, 0, 0, 6'h01, 3, 32'h2};
    vecs[2]  = '{1, enc(6'h01, 4, 3, 16'h0000),  0, 1, 3, 0, 0, 0, 6'h01, 3, 32'h2};
    vecs[3]  = '{1, enc(6'h01, 4, 3, 16'h0000),  0, 0, 0, 1, 1, 1, 6'h01, 4, 32'h0};
    vecs[4]  = '{1, enc(6'h2B, 0, 7, 16'h4000),  0, 0, 0, 1, 1, 0, 6'h2B, 0, 32'h4000};
    vecs[5]  = '{1, enc(6'h00, 0, 0, 16'h8000),  0, 0, 0, 1, 1, 0, 6'h00, 0, 32'hFFFF8000};
    vecs[6]  = '{1, enc(6'h01, 4, 1, 16'h0000),  0, 1, 4, 0, 0, 0, 6'h00, 0, 32'hFFFF8000};
    vecs[7]  = '{1, enc(6'h01, 4, 1, 16'h0000),  0, 0, 0, 1, 1, 1, 6'h01, 4, 32'h0};
    vecs[8]  = '{1, enc(6'h01, 9, 0, 16'h0000),  0, 0, 0, 1, 1, 1, 6'h01, 9, 32'h0};
    vecs[9]  = '{1, enc(6'h01, 10, 0, 16'h0000), 1, 0, 0, 0, 0, 0, 6'h01, 9, 32'h0};
    vecs[10] = '{1, enc(6'h01, 11, 4, 16'h4800), 0, 0, 0, 1, 1, 1, 6'h01, 11, 32'h4800};
    vecs[11] = '{0, enc(6'h01, 12, 11, 16'h0000),0, 0, 0, 0, 0, 0, 6'h01, 11, 32'h4800};
    vecs[12] = '{1, enc(6'h01, 0, 2, 16'h0000),  0, 0, 0, 1, 1, 1, 6'h01, 0, 32'h0};
    vecs[13] = '{1, enc(6'h01, 1, 0, 16'h1000),  0, 0, 0, 0, 0, 0, 6'h01, 0, 32'h0};
    vecs[14] = '{1, enc(6'h01, 1, 0, 16'h1000),  0, 1, 0, 0, 0, 0, 6'h01, 0, 32'h0};
    vecs[15] = '{1, enc(6'h01, 1, 0, 16'h1000),  0, 0, 0, 1, 1, 1, 6'h01, 1, 32'h1000};

    // Reset held with a valid instruction pending.
    instr = enc(6'h01, 2, 5, 16'h0000);
    instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_we", {31'd0, ex_we}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_op", {26'd0, ex_op}, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", {31'd0, ex_valid}, 32'd1);
    chk("rel_rd", {27'd0, ex_rd}, 32'd2);
    chk("rel_we", {31'd0, ex_we}, 32'd1);
    chk("rel_waw_ready", {31'd0, instr_ready}, 32'd0);

    // Directed table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      instr = vecs[i].instr; instr_valid = vecs[i].valid; flush = vecs[i].flush;
      wb_enable = vecs[i].wb_en; wb_add = vecs[i].wb_add;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, instr_ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_r1", i), {27'd0, r1_add}, {27'd0, vecs[i].instr[20:16]});
      chk($sformatf("v%0d_r2", i), {27'd0, r2_add}, {27'd0, vecs[i].instr[15:11]});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_we", i), {31'd0, ex_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_op", i), {26'd0, ex_op}, {26'd0, vecs[i].exp_op});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].exp_rd});
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].exp_imm);
    end
    instr_valid = 1'b0; flush = 1'b0; wb_enable = 1'b0;

    // Scoreboard same-edge set/clear collision.
    sb_set_en = 1; sb_set_add = 5; sb_clr_en = 1; sb_clr_add = 5;
    @(posedge clk); #1;
    chk("sb_setwins", sb_busy, 32'h0000_0020);
    sb_set_add = 6;
    @(posedge clk); #1;
    chk("sb_set_clr", sb_busy, 32'h0000_0040);
    sb_set_add = 7; sb_flush = 1;
    @(posedge clk); #1;
    chk("sb_flush", sb_busy, 32'h0);
    sb_set_en = 0; sb_clr_en = 0; sb_flush = 0;

    // Random traffic, small register range to provoke hazards.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0:       op = 6'h00;
        1:       op = 6'h2B;
        default: op = 6'($urandom_range(1, 62));
      endcase
      instr = enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  {5'($urandom_range(0, 7)), 11'($urandom)});
      instr_valid = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      wb_enable   = ($urandom_range(0, 1) == 1);
      wb_add      = 5'($urandom_range(0, 7));
      model_cycle();
    end

    // Halt: sticky, blocks issue, cleared only by async reset.
    do_reset();
    instr = enc(6'h3F, 7, 0, 16'h0000); instr_valid = 1'b1;
    #1 chk("halt_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, ex_valid}, 32'd1);
    chk("halt_we", {31'd0, ex_we}, 32'd0);
    chk("halt_op", {26'd0, ex_op}, 32'h3F);
    instr = enc(6'h01, 1, 0, 16'h0000);
    for (int c = 0; c < 10; c++) begin
      #1 chk("halt_block", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      chk("halt_novalid", {31'd0, ex_valid}, 32'd0);
    end
    #2 reset = 1'b0;
    #1;
    chk("halt_async_clr", {31'd0, halted}, 32'd0);
    chk("halt_async_ready", {31'd0, instr_ready}, 32'd1);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_halt_issue", {31'd0, ex_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Pipeline stage directly upstream of the register file.
- Accepts 32-bit instructions from fetch and splits them into read addresses (r1_add, r2_add), a destination, an opcode and an immediate.
- Tracks pending register writes in a 32-entry busy scoreboard and stalls fetch on read-after-write hazards.
- Issues to execute with registered outputs, aligned with the register file's one-cycle registered read.

Parameters:
- NREG, 32, number of architectural registers (scoreboard depth).
- AW, 5, register address width (log2 NREG).
- OP_NOP, 6'h00, opcode that is issued but writes nothing.
- OP_STORE, 6'h2B, opcode that reads rs1/rs2 and writes nothing.
- OP_HALT, 6'h3F, opcode that blocks all further issue until reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- instr  input  32  fetched instruction: [31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  decode accepts instr this cycle (combinational).
- flush  input  1  discard the issuing slot and clear all busy bits.
- wb_enable  input  1  writeback retires a write this cycle (same signal as the register file's write_enable).
- wb_add  input  5  register retired by writeback.
- r1_add  output  5  register file read address 1 (combinational from instr).
- r2_add  output  5  register file read address 2 (combinational from instr).
- ex_valid  output  1  issued instruction valid to execute.
- ex_op  output  6  issued opcode.
- ex_rd  output  5  issued destination.
- ex_we  output  1  issued instruction writes ex_rd.
- ex_imm  output  32  sign-extended imm[15:0].
- halted  output  1  HALT has issued.

Behaviour:
- Reset (async, reset=0):
  - ex_valid=0, ex_op=0, ex_rd=0, ex_we=0, ex_imm=0, halted=0.
  - All busy bits cleared.
- r1_add=instr[20:16] and r2_add=instr[15:11] at all times. The register file samples them at the same edge decode issues, so the operand values and the ex_* outputs appear together one cycle later.
- writes_rd = (op != OP_NOP) && (op != OP_STORE) && (op != OP_HALT).
- hazard = busy[rs1] | busy[rs2] | (writes_rd & busy[rd]).
  - Both sources are always checked, even if unused (conservative).
  - The rd check prevents WAW reordering.
- instr_ready = !hazard && !halted && !flush.
- Issue occurs when instr_valid && instr_ready. At the next edge:
  - ex_valid=1, ex_op=op, ex_rd=rd, ex_we=writes_rd, ex_imm=sign-extended imm.
  - If writes_rd, busy[rd] is set.
  - If op==OP_HALT, halted=1.
- No issue: at the next edge ex_valid=0, ex_we=0; other ex_* fields hold their previous values.
- Writeback: wb_enable clears busy[wb_add] at the edge.
  - The register file also writes at that edge and a read issued at the same edge would return the old value, so no bypass exists.
  - A consumer of wb_add stalls through the wb cycle and issues on the following cycle.
- Same edge set and clear of one register (issue sets busy[x], wb clears busy[x]): set wins.
- Register 0 is an ordinary register with no hardwired zero, matching the register file; it is tracked normally.
- flush:
  - At the next edge ex_valid=0, ex_we=0, and all busy bits clear. The in-flight writes are squashed downstream.
  - flush overrides issue and wb in that cycle.
  - halted is unaffected.
- halted is sticky and cleared only by reset. Once set, instr_ready=0.
- Reset asserted mid-stall: all state clears immediately. After release, the pending instr issues if instr_valid.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OP_NOP, OP_STORE, OP_HALT;
  - field bit positions for op/rd/rs1/rs2/imm;
  - the AW/NREG constants shared with the register file.
- One sub-module: scoreboard (32 busy bits).
  - Inputs: set_en/set_add, clr_en/clr_add, flush.
  - Output: the busy vector.
  - Implements the set-wins priority.

Test Plan:
1. Reset: hold reset=0 with instr_valid=1 → ex_valid=0, busy=0, halted=0. Release reset → the instr issues on the first edge.
2. RAW stall: issue op=6'h01 rd=3. Next cycle, instr rs1=3 → instr_ready=0. Assert wb_enable=1, wb_add=3 → still 0 in the wb cycle, 1 the cycle after; issues with ex_valid=1.
3. Set-wins: with busy[5]=1, issue rd=5 (op 6'h01) in the same cycle as wb_add=5 is presented. Expected: instr_ready=0 due to the WAW hazard, so no issue. Then force the collision via the scoreboard unit test: set_add=clr_add=5 → busy[5]=1.
4. No-write ops: issue OP_STORE rs1=7 rs2=8, then OP_NOP → ex_we=0 both times, busy unchanged. imm=16'h8000 → ex_imm=32'hFFFF8000.
5. Flush: busy[2] and busy[9] set, flush=1 with instr_valid=1 → next cycle ex_valid=0 and busy=0; an instr reading r2 issues immediately after.
6. Halt: issue OP_HALT → halted=1 and instr_ready stays 0 for 10 cycles. Apply async reset=0 mid-cycle → halted=0 before the next edge.
